alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, key-locked, sequential successor to the core's 8-bit combinational ALU. Adds a registered start/done handshake, carry and zero flags, and iterative multi-cycle operations: multiply, variable shift left and variable shift right. Sits between the accumulator/register datapath and the control FSM, which issues `start` and waits for `done`. Only the correct locking key yields correct results.

## Interface
- `WIDTH`, 8: operand and result width, ≥4.
- `LOCK_KEY`, 8'hD2: correct unlocking key.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: operation request, sampled on rising edge when `busy`=0.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `opcode` input 4: requested operation, before key mixing.
- `locking_key` input 8: unlock key.
- `Y` output WIDTH: registered result, held until the next result.
- `carry` output 1: registered carry/borrow/overflow flag.
- `zero` output 1: registered, 1 when `Y`==0.
- `busy` output 1: multi-cycle operation in progress.
- `done` output 1: one-cycle pulse, `Y`/flags newly valid.

## Operation
- Effective opcode `eop` = `opcode` ^ `locking_key[7:4]` ^ `LOCK_KEY[7:4]`.
- Output mask M = nibble (`locking_key[3:0]` ^ `LOCK_KEY[3:0]`), replicated and truncated to WIDTH. The final `Y` = raw result ^ M. `zero` is computed on the masked `Y`.
- `eop` map and carry rule (carry is 0 unless stated):
  - 0 ADD A+B: carry = carry-out.
  - 1 SUB A−B: carry = borrow (A<B).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL1: carry = A[MSB].
  - 6 SHR1: carry = A[0].
  - 7 ROL, 8 ROR.
  - 9 INC: carry on wrap.
  - 10 DEC: carry on borrow.
  - 11 INV.
  - 12 MUL: low WIDTH bits of A*B; carry = 1 if the high half is nonzero.
  - 13 SHLV: A<<n, where n = B mod WIDTH; carry = last bit shifted out.
  - 14 SHRV: A>>n, logical; carry = last bit shifted out.
  - 15 CLR: Y=0.
- FSM states:
  - IDLE. On `start`, latch A, B, `eop` and M. For a single-cycle op (including SHLV/SHRV with n=0), register the result and pulse `done`; stay in IDLE. For MUL, go to MUL. For SHLV/SHRV with n>0, go to SHIFT.
  - MUL: shift-add multiplication, one multiplier bit per cycle, WIDTH iterations, then register the result, pulse `done` and return to IDLE. Use a 2·WIDTH internal accumulator.
  - SHIFT: one bit position per cycle, n iterations, then register the result, pulse `done` and return to IDLE.
- `start` while `busy`=1 is ignored; no queueing. Operand inputs may change freely after acceptance.
- A key change mid-operation has no effect, because `eop` and M are latched at acceptance.

## Timing
- t0 = the rising edge at which `start` is accepted.
- Single-cycle ops: `Y`, flags and `done` are registered at t0 and visible in the cycle after t0. `busy` stays 0. Back-to-back `start` every cycle is legal.
- MUL: `busy`=1 from after t0 until t0+WIDTH. Result and `done` are registered at edge t0+WIDTH. `busy`=0 in the `done` cycle.
- SHLV/SHRV: `done` is registered at edge t0+n.
- A new `start` is accepted in the cycle where `done`=1.
- `done` is high for exactly one cycle per accepted op. `Y` and flags hold between results.
- Reset values: `Y`=0, `carry`=0, `zero`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-operation aborts it immediately: no `done`, all outputs return to reset values.

## Test plan
- WIDTH=8, key 8'hD2, ADD A=200 B=100 → next cycle `Y`=44, `carry`=1, `zero`=0, `done` pulse, `busy` never high.
- MUL A=13 B=11 → `busy` high 8 cycles, `done` at t0+8, `Y`=0x8F, `carry`=0. Then MUL 16×16 → `Y`=0, `carry`=1, `zero`=1.
- SHLV A=0x81 B=3 → `done` at t0+3, `Y`=0x08, `carry`=0. SHRV A=0x81 B=8 (n=0) → single-cycle, `Y`=0x81.
- Key 8'hD3, ADD 1+1 → `Y`=0x13 (mask 0x11). Key 8'hC2, opcode ADD, A=5 B=3 → executes SUB, `Y`=2.
- During MUL, `start` with ADD pulsed at t0+2 → ignored, a single `done` at t0+8 with the MUL result. A new `start` in the `done` cycle is accepted.
- `rst` asserted at t0+4 of a MUL → outputs zero immediately, no `done` after release, next ADD works normally.

Source files
------------

// File: rtl/alu_seq.sv
// Key-locked sequential ALU: single-cycle ops complete at acceptance, MUL and
// variable shifts iterate one bit per cycle behind a start/busy/done handshake.
module alu_seq #(
   parameter int         WIDTH    = 8,
   parameter logic [7:0] LOCK_KEY = 8'hD2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   input  logic [7:0]       locking_key,
   output logic [WIDTH-1:0] Y,
   output logic             carry,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_MUL  = 4'd12;
   localparam logic [3:0] OP_SHLV = 4'd13;
   localparam logic [3:0] OP_SHRV = 4'd14;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [3:0]         eop_q, eop_d;
   logic [WIDTH-1:0]   mask_q, mask_d;

   logic [3:0]         eop_in;
   logic [WIDTH-1:0]   mask_in;
   logic [CW-1:0]      n_in;
   logic [WIDTH:0]     single_res;
   logic [2*WIDTH-1:0] mul_sum;
   logic [WIDTH-1:0]   shift_nxt;
   logic               shift_out;

   function automatic logic [WIDTH-1:0] rep_mask(input logic [3:0] nib);
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) m[i] = nib[i % 4];
      return m;
   endfunction

   // Returns {carry, result}; MUL and non-zero variable shifts never reach here.
   function automatic logic [WIDTH:0] alu1(input logic [3:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      logic             c;
      r = '0;
      c = 1'b0;
      case (op)
         4'd0:  {c, r} = {1'b0, a} + {1'b0, b};
         4'd1:  begin r = a - b; c = (a < b); end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  begin r = a << 1; c = a[WIDTH-1]; end
         4'd6:  begin r = a >> 1; c = a[0]; end
         4'd7:  r = {a[WIDTH-2:0], a[WIDTH-1]};
         4'd8:  r = {a[0], a[WIDTH-1:1]};
         4'd9:  begin r = a + 1'b1; c = &a; end
         4'd10: begin r = a - 1'b1; c = (a == '0); end
         4'd11: r = ~a;
         4'd13, 4'd14: r = a;
         default: r = '0;
      endcase
      return {c, r};
   endfunction

   assign eop_in     = opcode ^ locking_key[7:4] ^ LOCK_KEY[7:4];
   assign mask_in    = rep_mask(locking_key[3:0] ^ LOCK_KEY[3:0]);
   assign n_in       = CW'(32'(B) % 32'(WIDTH));
   assign single_res = alu1(eop_in, A, B);
   assign mul_sum    = acc_q + (b_q[0] ? mcand_q : '0);
   assign shift_nxt  = (eop_q == OP_SHLV) ? (a_q << 1) : (a_q >> 1);
   assign shift_out  = (eop_q == OP_SHLV) ? a_q[WIDTH-1] : a_q[0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      eop_d   = eop_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               eop_d  = eop_in;
               mask_d = mask_in;
               a_d    = A;
               b_d    = B;
               if (eop_in == OP_MUL) begin
                  state_d = S_MUL;
                  cnt_d   = '0;
                  acc_d   = '0;
                  mcand_d = {{WIDTH{1'b0}}, A};
               end else if ((eop_in == OP_SHLV || eop_in == OP_SHRV) && n_in != '0) begin
                  state_d = S_SHIFT;
                  cnt_d   = n_in;
               end else begin
                  y_d     = single_res[WIDTH-1:0] ^ mask_in;
                  carry_d = single_res[WIDTH];
                  zero_d  = ((single_res[WIDTH-1:0] ^ mask_in) == '0);
                  done_d  = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d   = mul_sum;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               y_d     = mul_sum[WIDTH-1:0] ^ mask_q;
               carry_d = |mul_sum[2*WIDTH-1:WIDTH];
               zero_d  = ((mul_sum[WIDTH-1:0] ^ mask_q) == '0);
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            a_d   = shift_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               y_d     = shift_nxt ^ mask_q;
               carry_d = shift_out;
               zero_d  = ((shift_nxt ^ mask_q) == '0);
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   // Operand/working registers need no reset: they are only read after a load.
   always_ff @(posedge clk) begin
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      eop_q   <= eop_d;
      mask_q  <= mask_d;
   end

   assign Y     = y_q;
   assign carry = carry_q;
   assign zero  = zero_q;
   assign done  = done_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed expectations (WIDTH=8).
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [3:0] opcode = '0;
   logic [7:0] locking_key = 8'hD2;
   logic [7:0] Y;
   logic       carry, zero, busy, done;

   int total = 0;
   int bad   = 0;
   int cyc, bc;

   alu_seq #(.WIDTH(8), .LOCK_KEY(8'hD2)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .opcode(opcode),
      .locking_key(locking_key), .Y(Y), .carry(carry), .zero(zero),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int c, output int b);
      c = 0;
      b = 0;
      while (done !== 1'b1 && c < 20) begin
         if (busy === 1'b1) b++;
         step();
         c++;
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      opcode = op;
      A      = a;
      B      = b;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      step();
      step();
      chk("rst_Y", Y, 0);
      chk("rst_carry", carry, 0);
      chk("rst_zero", zero, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      step();

      // ADD 200+100 = 300 -> 44, carry out
      issue(4'd0, 8'd200, 8'd100);
      chk("add_Y", Y, 44);
      chk("add_carry", carry, 1);
      chk("add_zero", zero, 0);
      chk("add_done", done, 1);
      chk("add_busy", busy, 0);
      step();
      chk("add_done_drop", done, 0);
      chk("add_Y_hold", Y, 44);

      // MUL 13*11 = 143, then back-to-back MUL 16*16 = 256 accepted in done cycle
      issue(4'd12, 8'd13, 8'd11);
      chk("mul_busy_t0", busy, 1);
      wait_done(cyc, bc);
      chk("mul_latency", cyc, 8);
      chk("mul_busy_cycles", bc, 8);
      chk("mul_busy_done", busy, 0);
      chk("mul_Y", Y, 8'h8F);
      chk("mul_carry", carry, 0);
      chk("mul_zero", zero, 0);
      issue(4'd12, 8'd16, 8'd16);
      chk("mul2_accept", busy, 1);
      wait_done(cyc, bc);
      chk("mul2_latency", cyc, 8);
      chk("mul2_Y", Y, 0);
      chk("mul2_carry", carry, 1);
      chk("mul2_zero", zero, 1);

      // SHLV 0x81<<3 = 0x08, last bit out 0
      issue(4'd13, 8'h81, 8'd3);
      wait_done(cyc, bc);
      chk("shlv_latency", cyc, 3);
      chk("shlv_busy_cycles", bc, 3);
      chk("shlv_Y", Y, 8'h08);
      chk("shlv_carry", carry, 0);

      // SHRV with n = 8 mod 8 = 0 completes in one cycle
      issue(4'd14, 8'h81, 8'd8);
      chk("shrv0_done", done, 1);
      chk("shrv0_busy", busy, 0);
      chk("shrv0_Y", Y, 8'h81);
      chk("shrv0_carry", carry, 0);

      // SHRV by 1: 0x81 -> 0x40, bit out 1
      issue(4'd14, 8'h81, 8'd1);
      wait_done(cyc, bc);
      chk("shrv1_latency", cyc, 1);
      chk("shrv1_Y", Y, 8'h40);
      chk("shrv1_carry", carry, 1);

      // Wrong low key nibble masks result with 0x11
      locking_key = 8'hD3;
      issue(4'd0, 8'd1, 8'd1);
      chk("mask_Y", Y, 8'h13);
      chk("mask_carry", carry, 0);

      // Wrong high key nibble turns ADD into SUB
      locking_key = 8'hC2;
      issue(4'd0, 8'd5, 8'd3);
      chk("remap_Y", Y, 8'h02);
      chk("remap_carry", carry, 0);

      // MUL 3*5 with an ignored ADD start and a key change mid-operation
      locking_key = 8'hD2;
      issue(4'd12, 8'd3, 8'd5);
      step();
      locking_key = 8'hD3;
      issue(4'd0, 8'd1, 8'd1);
      chk("ign_no_done", done, 0);
      chk("ign_busy", busy, 1);
      wait_done(cyc, bc);
      chk("ign_latency", cyc, 6);
      chk("ign_Y", Y, 8'h0F);
      chk("ign_carry", carry, 0);
      step();
      chk("ign_single_done", done, 0);
      locking_key = 8'hD2;

      // Reset mid-MUL aborts; outputs clear, no late done, next ADD works
      issue(4'd12, 8'd13, 8'd11);
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      chk("abort_Y", Y, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_carry", carry, 0);
      step();
      rst = 1'b0;
      bc = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1 || busy === 1'b1) bc++;
         step();
      end
      chk("abort_quiet", bc, 0);
      issue(4'd0, 8'd2, 8'd3);
      chk("post_Y", Y, 5);
      chk("post_done", done, 1);
      chk("post_zero", zero, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
